// File: rtl/pipe_pkg.sv
// Shared pipeline constants: FSM encodings for the stall controller and the NOP word.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pipe_pkg;

  // Stall-controller FSM encodings; value 3 is unused and recovers to RUN
  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERR      = 2'd2;

  // addi x0, x0, 0 -- loaded by a stage register when it is flushed
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts by one per cycle that inc is high, sticks at all-ones.
// Latency: q reflects an increment one cycle after inc.
// Backpressure: none; the caller gates inc.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] q
);

  // count up on inc, hold once the maximum value is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (inc && (q != {W{1'b1}})) begin
      q <= q + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Central stall/flush controller: memory freeze > branch redirect > load-use bubble, plus counters.
// Latency: control outputs are combinational in the same cycle; counters/state update next edge.
// Backpressure: a pending data-memory access freezes PC..EX/MEM and bubbles MEM/WB until ready.
module pipeline_stall_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             ifid_flush,
  output logic             idex_hold,
  output logic             idex_flush,
  output logic             exmem_hold,
  output logic             memwb_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cnt_load_use,
  output logic [CNT_W-1:0] cnt_flush,
  output logic [CNT_W-1:0] cnt_mem_wait,
  output logic [1:0]       state
);

  // wide enough to hold TIMEOUT itself, since the timer is compared against it
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [1:0]    stateQ;
  logic [TW-1:0] waitTimer;

  logic active;
  logic inErr;
  logic freeze;
  logic redirect;
  logic loadUse;
  logic timeoutHit;

  assign state  = stateQ;
  assign active = (stateQ == RUN) || (stateQ == MEM_WAIT);
  assign inErr  = (stateQ == ERR);

  // A frozen EX instruction keeps its redirect, so freeze masks both flushes;
  // a redirect squashes the ID instruction, so it masks the load-use request.
  assign freeze     = active && mem_req && !mem_ready;
  assign redirect   = active && !freeze && ex_branch_taken;
  assign loadUse    = active && !freeze && !ex_branch_taken && hazard;
  assign timeoutHit = (stateQ == MEM_WAIT) && freeze && (waitTimer == TW'(TIMEOUT));

  // decode hold/flush enables from the winning condition; all quiet under reset
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    ifid_flush  = 1'b0;
    idex_hold   = 1'b0;
    idex_flush  = 1'b0;
    exmem_hold  = 1'b0;
    memwb_flush = 1'b0;
    if (!rst) begin
      if (freeze || inErr) begin
        pc_hold     = 1'b1;
        ifid_hold   = 1'b1;
        idex_hold   = 1'b1;
        exmem_hold  = 1'b1;
        memwb_flush = 1'b1;
      end else if (redirect) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (loadUse) begin
        pc_hold    = 1'b1;
        ifid_hold  = 1'b1;
        idex_flush = 1'b1;
      end
    end
  end

  // memory-wait FSM with wait timer and sticky timeout flag
  always_ff @(posedge clk) begin
    if (rst) begin
      stateQ      <= RUN;
      waitTimer   <= '0;
      mem_timeout <= 1'b0;
    end else begin
      case (stateQ)
        RUN: begin
          if (freeze) begin
            stateQ    <= MEM_WAIT;
            waitTimer <= TW'(1);
          end
        end
        MEM_WAIT: begin
          if (timeoutHit) begin
            stateQ      <= ERR;
            mem_timeout <= 1'b1;
          end else if (freeze) begin
            waitTimer <= waitTimer + TW'(1);
          end else begin
            stateQ    <= RUN;
            waitTimer <= '0;
          end
        end
        ERR: begin
          stateQ <= ERR;
        end
        default: begin
          stateQ    <= RUN;
          waitTimer <= '0;
        end
      endcase
    end
  end

  sat_counter #(.W(CNT_W)) uLoadUseCnt (
    .clk (clk),
    .rst (rst),
    .inc (loadUse),
    .q   (cnt_load_use)
  );

  sat_counter #(.W(CNT_W)) uFlushCnt (
    .clk (clk),
    .rst (rst),
    .inc (redirect),
    .q   (cnt_flush)
  );

  sat_counter #(.W(CNT_W)) uMemWaitCnt (
    .clk (clk),
    .rst (rst),
    .inc (freeze),
    .q   (cnt_mem_wait)
  );

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Scoreboard bench for pipeline_stall_ctrl: directed per-cycle vectors with hand-computed responses.
// Latency: expectations describe the same cycle's combinational outputs and current register values.
// Backpressure: n/a; the monitor pops one expectation per cycle while the queue is non-empty.
module tb_pipeline_stall_ctrl;

  localparam int CW = 4;
  localparam int TO = 4;

  // control vector order: pc_hold, ifid_hold, ifid_flush, idex_hold, idex_flush, exmem_hold, memwb_flush
  localparam logic [6:0] NONE = 7'b0000000;
  localparam logic [6:0] LU   = 7'b1100100;
  localparam logic [6:0] RD   = 7'b0010100;
  localparam logic [6:0] FRZ  = 7'b1101011;

  typedef struct packed {
    logic [6:0]    ctrl;
    logic [1:0]    st;
    logic          to;
    logic [CW-1:0] lu;
    logic [CW-1:0] fl;
    logic [CW-1:0] mw;
  } obs_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hazard = 1'b0;
  logic exBranchTaken = 1'b0;
  logic memReq = 1'b0;
  logic memReady = 1'b0;

  logic pcHold, ifidHold, ifidFlush, idexHold, idexFlush, exmemHold, memwbFlush, memTimeout;
  logic [CW-1:0] cntLoadUse, cntFlush, cntMemWait;
  logic [1:0]    stateOut;

  obs_t  expQ[$];
  string nameQ[$];
  int    nVec = 0;
  int    nBad = 0;

  pipeline_stall_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard          (hazard),
    .ex_branch_taken (exBranchTaken),
    .mem_req         (memReq),
    .mem_ready       (memReady),
    .pc_hold         (pcHold),
    .ifid_hold       (ifidHold),
    .ifid_flush      (ifidFlush),
    .idex_hold       (idexHold),
    .idex_flush      (idexFlush),
    .exmem_hold      (exmemHold),
    .memwb_flush     (memwbFlush),
    .mem_timeout     (memTimeout),
    .cnt_load_use    (cntLoadUse),
    .cnt_flush       (cntFlush),
    .cnt_mem_wait    (cntMemWait),
    .state           (stateOut)
  );

  always #5 clk = ~clk;

  // drive one cycle of inputs just after the edge and queue the expected response
  task automatic vec(input string nm, input logic hz, input logic br, input logic rq,
                     input logic rd, input logic r, input logic [6:0] ctrl,
                     input logic [1:0] st, input logic to, input logic [CW-1:0] lu,
                     input logic [CW-1:0] fl, input logic [CW-1:0] mw);
    obs_t e;
    @(posedge clk);
    #1;
    hazard        = hz;
    exBranchTaken = br;
    memReq        = rq;
    memReady      = rd;
    rst           = r;
    e.ctrl = ctrl;
    e.st   = st;
    e.to   = to;
    e.lu   = lu;
    e.fl   = fl;
    e.mw   = mw;
    expQ.push_back(e);
    nameQ.push_back(nm);
  endtask

  // monitor: on the falling edge compare the DUT against the oldest expectation
  always @(negedge clk) begin
    obs_t  act;
    obs_t  e;
    string nm;
    if (expQ.size() > 0) begin
      e  = expQ.pop_front();
      nm = nameQ.pop_front();
      act.ctrl = {pcHold, ifidHold, ifidFlush, idexHold, idexFlush, exmemHold, memwbFlush};
      act.st   = stateOut;
      act.to   = memTimeout;
      act.lu   = cntLoadUse;
      act.fl   = cntFlush;
      act.mw   = cntMemWait;
      nVec++;
      if (act !== e) begin
        nBad++;
        $display("FAIL %s: got ctrl=%b st=%0d to=%b lu=%0d fl=%0d mw=%0d, want ctrl=%b st=%0d to=%b lu=%0d fl=%0d mw=%0d",
                 nm, act.ctrl, act.st, act.to, act.lu, act.fl, act.mw,
                 e.ctrl, e.st, e.to, e.lu, e.fl, e.mw);
      end
    end
  end

  // directed stimulus: name, hz br rq rd rst | ctrl st to lu fl mw
  initial begin
    vec("reset_masks_hazard", 1, 0, 0, 0, 1, NONE, 0, 0, 0, 0, 0);
    vec("idle",               0, 0, 0, 0, 0, NONE, 0, 0, 0, 0, 0);
    vec("load_use",           1, 0, 0, 0, 0, LU,   0, 0, 0, 0, 0);
    vec("load_use_done",      0, 0, 0, 0, 0, NONE, 0, 0, 1, 0, 0);
    vec("redirect_hazard",    1, 1, 0, 0, 0, RD,   0, 0, 1, 0, 0);
    vec("redirect_done",      0, 0, 0, 0, 0, NONE, 0, 0, 1, 1, 0);
    vec("single_cycle_mem",   0, 0, 1, 1, 0, NONE, 0, 0, 1, 1, 0);
    vec("after_single",       0, 0, 0, 0, 0, NONE, 0, 0, 1, 1, 0);
    vec("wait1",              0, 0, 1, 0, 0, FRZ,  0, 0, 1, 1, 0);
    vec("wait2",              0, 0, 1, 0, 0, FRZ,  1, 0, 1, 1, 1);
    vec("wait3",              0, 0, 1, 0, 0, FRZ,  1, 0, 1, 1, 2);
    vec("wait_ready",         0, 0, 1, 1, 0, NONE, 1, 0, 1, 1, 3);
    vec("wait_back_run",      0, 0, 0, 0, 0, NONE, 0, 0, 1, 1, 3);
    vec("frz_mask_br1",       0, 1, 1, 0, 0, FRZ,  0, 0, 1, 1, 3);
    vec("frz_mask_br_hz",     1, 1, 1, 0, 0, FRZ,  1, 0, 1, 1, 4);
    vec("release_redirect",   0, 1, 1, 1, 0, RD,   1, 0, 1, 1, 5);
    vec("after_release",      0, 0, 0, 0, 0, NONE, 0, 0, 1, 2, 5);
    vec("wait_again",         0, 0, 1, 0, 0, FRZ,  0, 0, 1, 2, 5);
    vec("req_drop_loaduse",   1, 0, 0, 0, 0, LU,   1, 0, 1, 2, 6);
    vec("after_drop",         0, 0, 0, 0, 0, NONE, 0, 0, 2, 2, 6);
    vec("to_w0",              0, 0, 1, 0, 0, FRZ,  0, 0, 2, 2, 6);
    vec("to_w1",              0, 0, 1, 0, 0, FRZ,  1, 0, 2, 2, 7);
    vec("to_w2",              0, 0, 1, 0, 0, FRZ,  1, 0, 2, 2, 8);
    vec("to_w3",              0, 0, 1, 0, 0, FRZ,  1, 0, 2, 2, 9);
    vec("to_w4",              0, 0, 1, 0, 0, FRZ,  1, 0, 2, 2, 10);
    vec("err_entered",        1, 1, 1, 0, 0, FRZ,  2, 1, 2, 2, 11);
    vec("err_sticky_ready",   0, 0, 1, 1, 0, FRZ,  2, 1, 2, 2, 11);
    vec("err_counters_stop",  1, 1, 0, 0, 0, FRZ,  2, 1, 2, 2, 11);
    vec("err_rst_cycle",      1, 0, 0, 0, 1, NONE, 2, 1, 2, 2, 11);
    vec("after_rst",          0, 0, 0, 0, 0, NONE, 0, 0, 0, 0, 0);
    for (int k = 0; k < 20; k++) begin
      vec($sformatf("sat_%0d", k), 1, 0, 0, 0, 0, LU, 0, 0,
          CW'((k < 15) ? k : 15), 0, 0);
    end
    vec("sat_hold",           0, 0, 0, 0, 0, NONE, 0, 0, 15, 0, 0);
    @(posedge clk);
    #1;
    hazard = 1'b0;
    @(negedge clk);
    #1;
    if (expQ.size() != 0) begin
      nBad++;
      $display("FAIL drain: got %0d unchecked vectors, want 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end

endmodule
